emd_reconstructor: RTL
======================

EMD_RECONSTRUCTOR -- requirements
Module: emd_reconstructor

Interface
REQ-001 Parameter MAX_COMP, default 8: maximum number of components per frame (IMFs plus residue), range 2..15.
REQ-002 Parameter ACC_W, default 20: accumulator width in bits, at least 16 + ceil(log2(MAX_COMP)).
REQ-003 Port CLK  input  1  system clock; all logic rising-edge triggered; one clock; reset is synchronous and active-low.
REQ-004 Port rst_n  input  1  synchronous active-low reset.
REQ-005 Port start  input  1  single-cycle pulse opening a reconstruction frame.
REQ-006 Port Din  input  16  signed two's-complement component sample (IMF or residue).
REQ-007 Port din_valid  input  1  Din valid this cycle.
REQ-008 Port din_last  input  1  qualifies din_valid; marks the final component of the frame (the residue).
REQ-009 Port Xout  output  16  signed reconstructed sample (sum of all frame components, saturated).
REQ-010 Port xout_valid  output  1  single-cycle pulse: Xout updated.
REQ-011 Port sat  output  1  Xout was clamped; valid with xout_valid.
REQ-012 Port comp_cnt  output  4  number of components accepted in the current or most recent frame.
REQ-013 Port busy  output  1  high while in ACCUM.
REQ-014 Port err  output  1  sticky frame-overrun flag, cleared by accepted start or reset.

Function
REQ-015 The FSM SHALL have two states: IDLE and ACCUM; busy = (state == ACCUM).
REQ-016 In IDLE, start=1 SHALL move to ACCUM and clear the accumulator, comp_cnt and err; din_valid in IDLE SHALL be ignored.
REQ-017 In ACCUM, each din_valid cycle SHALL add sign-extended Din to the ACC_W accumulator and increment comp_cnt.
REQ-018 A beat with din_valid=1 and din_last=1 SHALL close the frame on that edge: Xout <= sat16(acc + Din), xout_valid <= 1, state <= IDLE.
REQ-019 xout_valid SHALL be high for exactly the one cycle after the closing beat (latency 1 clock); Xout SHALL hold its value until the next closing beat.
REQ-020 sat16 SHALL clamp to [-32768, 32767]; sat SHALL be 1 with xout_valid when clamping occurred, else 0; sat SHALL be 0 whenever xout_valid is 0.
REQ-021 Overrun: a din_valid beat with din_last=0 that makes comp_cnt equal MAX_COMP SHALL set err=1 and return to IDLE without xout_valid; the accumulator value is discarded.
REQ-022 start=1 in ACCUM SHALL abort and restart the frame (accumulator, comp_cnt cleared; err cleared); a din_valid beat in the same cycle SHALL be discarded.
REQ-023 start=1 in the cycle xout_valid is high SHALL be accepted normally (back-to-back frames, no dead cycle).
REQ-024 din_last without din_valid SHALL have no effect.
REQ-025 A single-beat frame (first beat carries din_last) SHALL output that sample unchanged.
REQ-026 The accumulator SHALL NOT wrap for any frame of at most MAX_COMP full-scale components.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state=IDLE, accumulator=0, Xout=0, xout_valid=0, sat=0, comp_cnt=0, busy=0, err=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no xout_valid; the first start after release SHALL behave as from power-up.
REQ-029 Reset SHALL take priority over start and din_valid in the same cycle.

Verification
REQ-030 start; Din 100, -30, 5(last) on consecutive cycles -> cycle after last: Xout=75, xout_valid=1 for one cycle, sat=0, comp_cnt=3, busy=0.
REQ-031 start; Din 20000 x3, 20000(last) -> Xout=32767, sat=1; then start; Din -20000, -20000(last) -> Xout=-32768, sat=1.
REQ-032 MAX_COMP=8; start; 8 beats of 1 with din_last=0 -> err=1 and busy=0 after 8th beat, no xout_valid; next start clears err.
REQ-033 start; 2 beats; rst_n=0 one cycle -> all outputs 0; start; Din -7(last) -> Xout=-7, comp_cnt=1.
REQ-034 start; Din 50; start with din_valid Din 999; Din 3(last) -> Xout=3, comp_cnt=1.
REQ-035 Closing beat followed immediately by start and a second frame 1, 1(last) -> two xout_valid pulses with Xout per frame, no lost beats.

Source files
------------

// File: rtl/emd_reconstructor.sv
// Sums the IMF and residue components of a frame and saturates the total to 16 bits.
// Latency is 1 clock from the closing beat to xout_valid. There is no backpressure: every din_valid beat taken in ACCUM is consumed.
module emd_reconstructor #(
  parameter int MAX_COMP = 8,
  parameter int ACC_W    = 20
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] Din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic [15:0] Xout,
  output logic        xout_valid,
  output logic        sat,
  output logic [3:0]  comp_cnt,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [3:0]              MAX_CNT = 4'(MAX_COMP);
  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(-32768);

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt, sum;
  logic [15:0]             xout_nxt;
  logic [3:0]              cnt_nxt;
  logic                    xv_nxt, sat_nxt, err_nxt;

  assign busy = (state == ACCUM);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = comp_cnt;
    xout_nxt  = Xout;
    xv_nxt    = 1'b0;
    sat_nxt   = 1'b0;
    err_nxt   = err;
    sum       = acc + {{(ACC_W-16){Din[15]}}, Din};
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      ACCUM: begin
        // A restart wins over any beat arriving in the same cycle.
        if (start) begin
          acc_nxt = '0;
          cnt_nxt = '0;
          err_nxt = 1'b0;
        end else if (din_valid) begin
          cnt_nxt = comp_cnt + 4'd1;
          if (din_last) begin
            state_nxt = IDLE;
            xv_nxt    = 1'b1;
            if (sum > POS_LIM) begin
              xout_nxt = 16'h7fff;
              sat_nxt  = 1'b1;
            end else if (sum < NEG_LIM) begin
              xout_nxt = 16'h8000;
              sat_nxt  = 1'b1;
            end else begin
              xout_nxt = sum[15:0];
            end
          end else if (cnt_nxt == MAX_CNT) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            acc_nxt = sum;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      Xout       <= '0;
      xout_valid <= 1'b0;
      sat        <= 1'b0;
      comp_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      Xout       <= xout_nxt;
      xout_valid <= xv_nxt;
      sat        <= sat_nxt;
      comp_cnt   <= cnt_nxt;
      err        <= err_nxt;
    end
  end

endmodule
